// File: rtl/pipefetch_fifo.sv
// Pipelined Wishbone instruction prefetch with an in-order instruction FIFO.
// Up to DEPTH word reads may be in flight. Bus slots are reserved by counting
// buffered entries plus outstanding requests, so the FIFO can never overflow.
//
// Handshakes:
//   decode side : an entry moves to decode on a cycle where o_valid && i_stalled_n.
//                 o_valid never depends on i_stalled_n.
//   bus side    : a request is taken on a cycle where o_wb_stb && !i_wb_stall.
//                 o_wb_stb/o_wb_addr are held while the slave stalls.
//                 Each taken request is answered by exactly one ack or err while o_wb_cyc is high.
module pipefetch_fifo #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int LGDEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_new_pc,
  input  logic [AW-1:0] i_pc,
  input  logic          i_stalled_n,
  output logic          o_valid,
  output logic [DW-1:0] o_insn,
  output logic [AW-1:0] o_pc,
  output logic          o_illegal,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam int CW    = LGDEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    HALTED  = 2'd0,
    RUN     = 2'd1,
    ERRWAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [CW-1:0]      outst_q, outst_d;
  logic [CW-1:0]      fill_q, fill_d;
  logic [CW-1:0]      space_d;
  logic [LGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
  // Each entry is {illegal, instruction}.
  logic [DW:0]        mem_q [DEPTH];
  logic [DW:0]        mem_d [DEPTH];

  logic               accept;
  logic               ack_ok;
  logic               err_ok;
  logic               consume;
  logic               wr_en;
  logic [DW:0]        wr_entry;
  logic [DW:0]        head;

  // Qualify bus and decode events; responses only count while a cycle is open and fetching.
  always_comb begin
    accept  = stb_q && !i_wb_stall && (state_q == RUN);
    err_ok  = cyc_q && i_wb_err && (state_q == RUN);
    ack_ok  = cyc_q && i_wb_ack && !i_wb_err && (state_q == RUN) && (outst_q != '0);
    consume = (fill_q != '0) && i_stalled_n;
  end

  // Next-state, counters, pointers and bus control; a branch overrides everything else.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    addr_d   = addr_q;
    pc_d     = pc_q;
    outst_d  = outst_q;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    space_d  = '0;
    wr_en    = 1'b0;
    wr_entry = '0;
    if (i_new_pc) begin
      state_d  = RUN;
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      addr_d   = i_pc;
      pc_d     = i_pc;
      outst_d  = '0;
      fill_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (err_ok) begin
        wr_en    = 1'b1;
        wr_entry = {1'b1, {DW{1'b0}}};
      end else if (ack_ok) begin
        wr_en    = 1'b1;
        wr_entry = {1'b0, i_wb_data};
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + LGDEPTH'(1);
      end
      if (consume) begin
        rd_ptr_d = rd_ptr_q + LGDEPTH'(1);
        pc_d     = pc_q + AW'(1);
      end
      fill_d = fill_q + CW'(wr_en) - CW'(consume);
      if (err_ok) begin
        // The error entry used the slot its request reserved; abandon the rest.
        state_d = ERRWAIT;
        outst_d = '0;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end else if (state_q == RUN) begin
        if (accept) begin
          addr_d = addr_q + AW'(1);
        end
        outst_d = outst_q + CW'(accept) - CW'(ack_ok);
        space_d = DEPTH_C - fill_d - outst_d;
        stb_d   = (space_d != '0);
        cyc_d   = stb_d || (outst_d != '0);
      end else begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    end
  end

  // FIFO storage write port.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= HALTED;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      addr_q   <= '0;
      pc_q     <= '0;
      outst_q  <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // First-word-fall-through head; payload is forced to zero while empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    o_valid   = (fill_q != '0);
    o_insn    = o_valid ? head[DW-1:0] : '0;
    o_illegal = o_valid && head[DW];
  end

  assign o_pc      = pc_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_addr = addr_q;
  assign o_wb_we   = 1'b0;
  assign o_wb_data = '0;

endmodule

// File: tb/tb_pipefetch_fifo.sv
// Bench for pipefetch_fifo: Wishbone slave model, decode-side consumer and an
// in-order scoreboard of {illegal, pc, insn} entries.
module tb_pipefetch_fifo;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int EW    = 1 + AW + DW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_new_pc = 1'b0;
  logic [AW-1:0] i_pc = '0;
  logic          i_stalled_n = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_insn;
  logic [AW-1:0] o_pc;
  logic          o_illegal;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_ack = 1'b0;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_err = 1'b0;
  logic [DW-1:0] i_wb_data = '0;

  pipefetch_fifo #(.AW(AW), .DW(DW), .LGDEPTH(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_new_pc(i_new_pc), .i_pc(i_pc),
    .i_stalled_n(i_stalled_n), .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc),
    .o_illegal(o_illegal), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack),
    .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] pc;
    int            cycles;
    int            ready_pct;
    int            stall_pct;
    int            exp_out;
  } vec_t;

  vec_t          vecs[5];
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] pend_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            ready_pct = 100;
  int            stall_pct = 0;
  bit            ack_hold = 1'b0;
  bit            err_en = 1'b0;
  bit            err_seen = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [AW-1:0] next_addr = '0;
  int            accepts = 0;
  int            outputs = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {a, 2'b01} ^ 32'hC3A5_0F00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of consumer + slave activity; inputs set before the edge, outputs read 1ns after.
  task automatic cycle_step();
    logic [EW-1:0] e;
    logic [AW-1:0] a;
    bit            err_before;
    err_before  = err_seen;
    i_stalled_n = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
    if (!i_new_pc) begin
      check("valid_vs_model", o_valid, exp_q.size() != 0);
      check("capacity", (pend_q.size() + exp_q.size()) <= DEPTH, 1'b1);
      if (o_valid && i_stalled_n) begin
        outputs++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got o_pc=%0h expected no entry", o_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", o_pc, e[DW +: AW]);
          check("out_insn", o_insn, e[DW-1:0]);
          check("out_illegal", o_illegal, e[EW-1]);
        end
      end
    end
    // Slave: answer the oldest taken request one cycle (or more, when held) later.
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = '0;
    i_wb_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
    if (!o_wb_cyc) begin
      pend_q.delete();
    end else if (pend_q.size() != 0 && !ack_hold) begin
      a = pend_q.pop_front();
      if (err_en && a == err_addr) begin
        i_wb_err = 1'b1;
        pend_q.delete();
        if (!i_new_pc) begin
          exp_q.push_back({1'b1, a, {DW{1'b0}}});
          err_seen = 1'b1;
        end
      end else begin
        i_wb_ack  = 1'b1;
        i_wb_data = data_of(a);
        if (!i_new_pc) exp_q.push_back({1'b0, a, data_of(a)});
      end
    end
    if (o_wb_stb && !i_wb_stall && !i_new_pc) begin
      check("req_addr", o_wb_addr, next_addr);
      if (err_before) begin
        n_vec++;
        n_bad++;
        $display("FAIL fetch_after_err: got request at %0h expected none", o_wb_addr);
      end
      if (!o_wb_cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL stb_without_cyc: got cyc=0 expected 1");
      end
      next_addr = next_addr + 1'b1;
      pend_q.push_back(o_wb_addr);
      accepts++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic branch(input logic [AW-1:0] pc);
    i_new_pc = 1'b1;
    i_pc     = pc;
    cycle_step();
    i_new_pc = 1'b0;
    exp_q.delete();
    pend_q.delete();
    next_addr = pc;
    err_seen  = 1'b0;
    accepts   = 0;
    outputs   = 0;
    check("flush_addr", o_wb_addr, pc);
    check("flush_pc", o_pc, pc);
    check("flush_valid", o_valid, 1'b0);
    check("flush_cyc", o_wb_cyc, 1'b0);
  endtask

  initial begin
    vecs[0] = '{30'h100,      20, 100,  0, 17};
    vecs[1] = '{30'h3FFFFFFF, 12, 100,  0,  9};
    vecs[2] = '{30'h1234,     80,  60, 30, -1};
    vecs[3] = '{30'h2000,     80,  30, 50, -1};
    vecs[4] = '{30'h3FFFFFFC, 40,  80, 20, -1};

    // Reset values and idle without a branch
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_cyc", o_wb_cyc, 1'b0);
    check("rst_stb", o_wb_stb, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_illegal", o_illegal, 1'b0);
    check("rst_insn", o_insn, 0);
    check("rst_pc", o_pc, 0);
    check("rst_addr", o_wb_addr, 0);
    check("rst_we", o_wb_we, 1'b0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle_step();
      check("idle_cyc", o_wb_cyc, 1'b0);
      check("idle_valid", o_valid, 1'b0);
    end

    // Table rows: streaming, wrap, random backpressure on both sides
    foreach (vecs[v]) begin
      ready_pct = vecs[v].ready_pct;
      stall_pct = vecs[v].stall_pct;
      branch(vecs[v].pc);
      for (int c = 0; c < vecs[v].cycles; c++) cycle_step();
      if (vecs[v].exp_out >= 0) check("row_outputs", outputs, vecs[v].exp_out);
    end

    // Decode backpressure: exactly DEPTH requests, bus cycle closes, then resumes at 0x104
    ready_pct = 0;
    stall_pct = 0;
    branch(30'h100);
    for (int c = 0; c < 15; c++) cycle_step();
    check("bp_accepts", accepts, DEPTH);
    check("bp_stb", o_wb_stb, 1'b0);
    check("bp_cyc", o_wb_cyc, 1'b0);
    check("bp_valid", o_valid, 1'b1);
    check("bp_pc", o_pc, 30'h100);
    ready_pct = 100;
    outputs   = 0;
    for (int c = 0; c < 20; c++) cycle_step();
    check("bp_resume_outputs", outputs, 20);

    // Branch while three reads are in flight and their acks are returning
    ready_pct = 0;
    ack_hold  = 1'b1;
    branch(30'h200);
    for (int g = 0; g < 10 && accepts < 3; g++) cycle_step();
    check("mid_outstanding", accepts, 3);
    ack_hold  = 1'b0;
    ready_pct = 100;
    branch(30'h40);
    for (int g = 0; g < 10 && !o_valid; g++) cycle_step();
    check("mid_first_valid", o_valid, 1'b1);
    check("mid_first_pc", o_pc, 30'h40);
    check("mid_first_insn", o_insn, data_of(30'h40));
    for (int c = 0; c < 10; c++) cycle_step();

    // Bus error on 0x305
    err_en   = 1'b1;
    err_addr = 30'h305;
    branch(30'h300);
    for (int c = 0; c < 25; c++) cycle_step();
    check("err_outputs", outputs, 6);
    check("err_cyc", o_wb_cyc, 1'b0);
    check("err_stb", o_wb_stb, 1'b0);
    check("err_valid", o_valid, 1'b0);
    err_en = 1'b0;

    // Asynchronous reset in the middle of streaming
    branch(30'h500);
    for (int c = 0; c < 8; c++) cycle_step();
    check("pre_rst_cyc", o_wb_cyc, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_cyc", o_wb_cyc, 1'b0);
    check("arst_stb", o_wb_stb, 1'b0);
    check("arst_valid", o_valid, 1'b0);
    check("arst_addr", o_wb_addr, 0);
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    exp_q.delete();
    pend_q.delete();
    err_seen = 1'b0;
    i_rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle_step();
      check("post_rst_cyc", o_wb_cyc, 1'b0);
      check("post_rst_valid", o_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Run-time guard
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipefetch_fifo.md
Name: pipefetch_fifo

Overview:
- Pipelined Wishbone instruction prefetch for the ZipCPU core.
- Keeps up to 2^LGDEPTH word reads in flight and buffers returned instructions in an internal FIFO.
- Hands instructions to the decode stage in order, one per accepted cycle.
- Branches (i_new_pc) flush the FIFO and discard in-flight returns. Bus errors are delivered as a tagged illegal instruction.

Parameters:
- AW, 30: word-address width of o_wb_addr, i_pc and o_pc.
- DW, 32: instruction/bus data width.
- LGDEPTH, 2: log2 of FIFO depth. DEPTH = 2^LGDEPTH. Legal range 1..5.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_new_pc  in  1  branch request: flush and restart fetch at i_pc.
- i_pc  in  AW  branch target word address, sampled when i_new_pc=1.
- i_stalled_n  in  1  decode ready; head entry is consumed when o_valid && i_stalled_n.
- o_valid  out  1  head entry present.
- o_insn  out  DW  head instruction word.
- o_pc  out  AW  word address of head entry.
- o_illegal  out  1  head entry came from a bus error.
- o_wb_cyc, o_wb_stb  out  1 each  Wishbone cycle/strobe.
- o_wb_we  out  1  constant 0.
- o_wb_addr  out  AW  request address.
- o_wb_data  out  DW  constant 0.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  Wishbone responses.
- i_wb_data  in  DW  read data.

Behaviour:
- **Reset (i_rst_n=0, async):**
  - cyc=stb=0, o_valid=0, o_illegal=0, o_insn=0, o_pc=0, o_wb_addr=0.
  - FIFO empty, outstanding count=0.
  - State HALTED: nothing is fetched until the first i_new_pc.
- **States:**
  - HALTED: idle, no fetch.
  - RUN: fetching.
  - ERRWAIT: a bus error was seen; fetching stopped.
- **Flush (i_new_pc=1, any state, highest priority after reset):**
  - Next cycle: cyc=stb=0, FIFO empty, outstanding=0, o_valid=0.
  - o_wb_addr=i_pc, o_pc=i_pc, state=RUN.
  - Any ack/err in the flush cycle is discarded.
  - The head is not consumed in the flush cycle even if i_stalled_n=1.
- **Space accounting:** space = DEPTH - fill - outstanding, width LGDEPTH+1.
- **Issue (RUN):**
  - stb=1 whenever space>0 after this cycle's updates.
  - cyc=1 whenever stb=1 or outstanding>0.
  - A request is accepted when stb && !i_wb_stall; then o_wb_addr += 1 (wraps modulo 2^AW) and outstanding += 1.
  - First stb rises the cycle after a flush (one idle cycle).
- **Completion:**
  - ack: outstanding -= 1; {i_wb_data, 0} is written at the FIFO tail.
  - Accept, ack and consume may all occur in one cycle; counters must net correctly.
- **Error (err while cyc, RUN):**
  - Write {0, illegal=1} entry; next cycle cyc=stb=0, outstanding=0, state=ERRWAIT.
  - Later acks are ignored. ERRWAIT leaves only via i_new_pc.
- **Cycle drop:** cyc falls the cycle after outstanding reaches 0 with space=0. It re-rises with stb when space returns.
- **Output:**
  - o_valid = fill>0. o_insn/o_illegal come from the FIFO head (registered or FWFT; zero extra latency beyond FIFO write).
  - Minimum latency: ack on cycle N gives o_valid on cycle N+1.
  - o_pc increments by 1 per consume (mod 2^AW).
- **Capacity:**
  - FIFO never overflows: issue is gated by space.
  - Consume with o_valid=0 has no effect.

Test Plan:
- **Reset/idle:** release reset, no i_new_pc for 10 cycles -> cyc=0, o_valid=0 throughout.
- **Streaming:** i_new_pc, i_pc=0x100, zero-wait slave (ack 1 cycle after accept), i_stalled_n=1 -> addresses 0x100,0x101,... issued back-to-back; o_pc 0x100,0x101,... with matching data; one instruction per cycle sustained.
- **Backpressure:** LGDEPTH=2, i_stalled_n=0 -> exactly 4 accepts, then stb=0 and cyc drops; raise i_stalled_n -> fetch resumes at 0x104 with no loss or duplication.
- **Branch mid-flight:** 3 outstanding at 0x200.., i_new_pc to 0x40 while acks return -> stale data never reaches o_valid; first output is o_pc=0x40.
- **Bus error:** err on the request for 0x305 -> entries 0x300..0x304 normal, then o_illegal=1 at o_pc=0x305; no further fetch until i_new_pc.
- **Wrap and async reset:** i_pc=0x3FFFFFFF -> next address 0x0; assert i_rst_n low mid-cycle -> cyc/stb/o_valid fall immediately, without waiting for a clock edge.
